// File: rtl/lram_pkg.sv
// Shared types for the line RAM fill controller: fill state, widths and index types.
package lram_pkg;

    localparam int LRAM_AW = 10;
    localparam int VRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fill_state_t;

    typedef logic [LRAM_AW-1:0] line_idx_t;
    // One extra bit so a full 1024-word line can be counted to completion.
    typedef logic [LRAM_AW:0]   word_idx_t;

endpackage

// File: rtl/lfill_addr_gen.sv
// VRAM read address generation: display line counter, per-fill latches of line and
// x start, and the x-wrapped word address presented to the VRAM arbiter.
module lfill_addr_gen
    import lram_pkg::*;
#(
    parameter int VAW = 20
) (
    input  logic                 gclk,
    input  logic                 rstn,
    input  logic                 vpstart,
    input  logic                 vrtc,
    input  logic                 fill_start,
    input  logic [LRAM_AW-1:0]   yscroll,
    input  logic [LRAM_AW-1:0]   xscroll,
    input  line_idx_t            req_lo,
    output logic [VAW-1:0]       vram_addr
);

    line_idx_t line_cnt_q, line_cnt_d;
    line_idx_t fill_line_q, fill_line_d;
    line_idx_t x_base_q, x_base_d;
    line_idx_t x_cur;

    always_comb begin
        line_cnt_d  = line_cnt_q;
        fill_line_d = fill_line_q;
        x_base_d    = x_base_q;
        if (fill_start) begin
            fill_line_d = line_cnt_q;
            x_base_d    = xscroll;
            if (vrtc) begin
                line_cnt_d = line_cnt_q + 10'd1;
            end
        end
        if (vpstart) begin
            line_cnt_d = yscroll;
        end
        // 10-bit add wraps the x position at the end of the VRAM line.
        x_cur = x_base_q + req_lo;
    end

    always_ff @(posedge gclk) begin
        if (!rstn) begin
            line_cnt_q  <= '0;
            fill_line_q <= '0;
            x_base_q    <= '0;
        end else begin
            line_cnt_q  <= line_cnt_d;
            fill_line_q <= fill_line_d;
            x_base_q    <= x_base_d;
        end
    end

    assign vram_addr = VAW'({fill_line_q, x_cur});

endmodule

// File: rtl/lram_fill_ctrl.sv
// Line RAM refill sequencer; `define LFILL_UNDERRUN_CNT_EN adds a saturating underrun_cnt.
// IDLE: wait for hcomp | FETCH: request words, write returned beats | DRAIN: discard old beats, then refill
module lram_fill_ctrl
    import lram_pkg::*;
#(
    parameter int LWORDS = 512,
    parameter int MAXOUT = 2,
    parameter int VAW    = 20
) (
    input  logic                 gclk,
    input  logic                 rstn,
    input  logic                 hcomp,
    input  logic                 vpstart,
    input  logic                 vrtc,
    input  logic [LRAM_AW-1:0]   yscroll,
    input  logic [LRAM_AW-1:0]   xscroll,
    output logic                 vram_req,
    output logic [VAW-1:0]       vram_addr,
    input  logic                 vram_ack,
    input  logic                 vram_rvalid,
    input  logic [VRAM_DW-1:0]   vram_rdat,
    output logic                 lram_we,
    output logic                 lram_wsel,
    output logic [LRAM_AW-1:0]   lram_wadr,
    output logic [VRAM_DW-1:0]   lram_wdat,
    output logic                 busy,
    output logic                 underrun,
    input  logic                 clr_underrun
`ifdef LFILL_UNDERRUN_CNT_EN
    ,
    output logic [7:0]           underrun_cnt
`endif
);

    localparam word_idx_t   LW = word_idx_t'(LWORDS);
    localparam logic [2:0]  MO = 3'(MAXOUT);

    fill_state_t          state_q, state_d;
    word_idx_t            reqidx_q, reqidx_d;
    word_idx_t            wridx_q, wridx_d;
    logic [2:0]           out_q, out_d, out_nxt;
    logic                 wsel_q, wsel_d;
    logic                 we_q, we_d;
    line_idx_t            wadr_q, wadr_d;
    logic [VRAM_DW-1:0]   wdat_q, wdat_d;
    logic                 unr_q, unr_d;
    logic                 req_c, ack_c, rv_c, unr_set, fill_start;

    always_comb begin
        req_c   = (state_q == FETCH) && (reqidx_q < LW) && (out_q < MO);
        ack_c   = req_c && vram_ack;
        rv_c    = vram_rvalid && (state_q != IDLE) && (out_q != 3'd0);
        out_nxt = out_q + {2'b00, ack_c} - {2'b00, rv_c};

        state_d    = state_q;
        reqidx_d   = reqidx_q;
        wridx_d    = wridx_q;
        out_d      = out_nxt;
        wsel_d     = hcomp ? ~wsel_q : wsel_q;
        we_d       = 1'b0;
        wadr_d     = wadr_q;
        wdat_d     = wdat_q;
        unr_set    = 1'b0;
        fill_start = 1'b0;

        case (state_q)
            IDLE: begin
                out_d = '0;
                if (hcomp) begin
                    state_d    = FETCH;
                    fill_start = 1'b1;
                    reqidx_d   = '0;
                    wridx_d    = '0;
                end
            end
            FETCH: begin
                if (hcomp) begin
                    // Beats of the abandoned line are never written into the new bank.
                    unr_set  = 1'b1;
                    reqidx_d = '0;
                    wridx_d  = '0;
                    if (out_nxt != 3'd0) begin
                        state_d = DRAIN;
                    end else begin
                        fill_start = 1'b1;
                    end
                end else begin
                    if (ack_c) begin
                        reqidx_d = reqidx_q + 11'd1;
                    end
                    if (rv_c) begin
                        we_d    = 1'b1;
                        wadr_d  = wridx_q[LRAM_AW-1:0];
                        wdat_d  = vram_rdat;
                        wridx_d = wridx_q + 11'd1;
                        if ((wridx_q + 11'd1) == LW) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DRAIN: begin
                unr_set = hcomp;
                if (out_nxt == 3'd0) begin
                    state_d    = FETCH;
                    fill_start = 1'b1;
                    reqidx_d   = '0;
                    wridx_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        unr_d = unr_set | (unr_q & ~clr_underrun);
    end

    always_ff @(posedge gclk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            reqidx_q <= '0;
            wridx_q  <= '0;
            out_q    <= '0;
            wsel_q   <= 1'b1;
            we_q     <= 1'b0;
            wadr_q   <= '0;
            wdat_q   <= '0;
            unr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reqidx_q <= reqidx_d;
            wridx_q  <= wridx_d;
            out_q    <= out_d;
            wsel_q   <= wsel_d;
            we_q     <= we_d;
            wadr_q   <= wadr_d;
            wdat_q   <= wdat_d;
            unr_q    <= unr_d;
        end
    end

`ifdef LFILL_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;
    logic [7:0] ucnt_base;

    always_comb begin
        ucnt_base = clr_underrun ? 8'd0 : ucnt_q;
        ucnt_d    = ucnt_base;
        if (unr_set && (ucnt_base != 8'hFF)) begin
            ucnt_d = ucnt_base + 8'd1;
        end
    end

    always_ff @(posedge gclk) begin
        if (!rstn) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

    lfill_addr_gen #(
        .VAW (VAW)
    ) u_addr_gen (
        .gclk       (gclk),
        .rstn       (rstn),
        .vpstart    (vpstart),
        .vrtc       (vrtc),
        .fill_start (fill_start),
        .yscroll    (yscroll),
        .xscroll    (xscroll),
        .req_lo     (reqidx_q[LRAM_AW-1:0]),
        .vram_addr  (vram_addr)
    );

    assign vram_req  = req_c;
    assign lram_we   = we_q;
    assign lram_wsel = wsel_q;
    assign lram_wadr = wadr_q;
    assign lram_wdat = wdat_q;
    assign busy      = (state_q != IDLE);
    assign underrun  = unr_q;

endmodule

// File: tb/tb_lram_fill_ctrl.sv
// Directed bench for lram_fill_ctrl with a small in-order VRAM model and a line RAM write monitor.
module tb_lram_fill_ctrl;

    logic        gclk = 1'b0;
    logic        rstn = 1'b0;
    logic        hcomp = 1'b0;
    logic        vpstart = 1'b0;
    logic        vrtc = 1'b0;
    logic [9:0]  yscroll = '0;
    logic [9:0]  xscroll = '0;
    logic        vram_req;
    logic [19:0] vram_addr;
    logic        vram_ack;
    logic        vram_rvalid;
    logic [15:0] vram_rdat;
    logic        lram_we;
    logic        lram_wsel;
    logic [9:0]  lram_wadr;
    logic [15:0] lram_wdat;
    logic        busy;
    logic        underrun;
    logic        clr_underrun = 1'b0;
`ifdef LFILL_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 gclk = ~gclk;

    lram_fill_ctrl #(
        .LWORDS (512),
        .MAXOUT (2),
        .VAW    (20)
    ) dut (
        .gclk         (gclk),
        .rstn         (rstn),
        .hcomp        (hcomp),
        .vpstart      (vpstart),
        .vrtc         (vrtc),
        .yscroll      (yscroll),
        .xscroll      (xscroll),
        .vram_req     (vram_req),
        .vram_addr    (vram_addr),
        .vram_ack     (vram_ack),
        .vram_rvalid  (vram_rvalid),
        .vram_rdat    (vram_rdat),
        .lram_we      (lram_we),
        .lram_wsel    (lram_wsel),
        .lram_wadr    (lram_wadr),
        .lram_wdat    (lram_wdat),
        .busy         (busy),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
`ifdef LFILL_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] dfn(input logic [19:0] a);
        return a[15:0] ^ {a[19:16], 12'h5A3};
    endfunction

    // VRAM model: ack on request, in-order data 'lat' cycles after acceptance.
    typedef struct {
        logic [19:0] addr;
        int          due;
    } rd_t;

    rd_t         rq[$];
    logic [19:0] acc_q[$];
    int          cyc = 0;
    int          lat = 2;
    bit          ack_en = 1'b1;
    bit          rv_en = 1'b1;
    int          max_out = 0;
    int          both_cnt = 0;
    int          rv_cnt = 0;

    always @(negedge gclk) begin
        rd_t r;
        cyc++;
        vram_rvalid = 1'b0;
        if (rv_en && rq.size() > 0 && rq[0].due <= cyc) begin
            vram_rvalid = 1'b1;
            vram_rdat   = dfn(rq[0].addr);
            void'(rq.pop_front());
            rv_cnt++;
        end
        vram_ack = ack_en && vram_req;
        if (vram_ack) begin
            r.addr = vram_addr;
            r.due  = cyc + lat;
            rq.push_back(r);
            acc_q.push_back(vram_addr);
            if (vram_rvalid) both_cnt++;
        end
        if (rq.size() > max_out) max_out = rq.size();
    end

    // Write monitor: each write must be the next word of the expected line, in the expected bank.
    int          wr_cnt = 0;
    int          wr_bad = 0;
    int          mon_next = 0;
    logic [9:0]  mon_line = '0;
    logic [9:0]  mon_xs = '0;
    logic        mon_wsel = 1'b0;

    always @(negedge gclk) begin
        if (lram_we) begin
            if (lram_wadr !== 10'(mon_next) || lram_wsel !== mon_wsel ||
                lram_wdat !== dfn({mon_line, 10'(mon_xs + 10'(mon_next))}))
                wr_bad++;
            mon_next++;
            wr_cnt++;
        end
    end

    logic exp_wsel = 1'b1;
    int   acc_base = 0;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge gclk);
            #1;
        end
    endtask

    task automatic start_fill(input logic [9:0] ln, input logic [9:0] xs);
        mon_line = ln;
        mon_xs   = xs;
        mon_next = 0;
        wr_cnt   = 0;
        wr_bad   = 0;
        acc_base = acc_q.size();
        mon_wsel = ~exp_wsel;
        xscroll  = xs;
        hcomp    = 1'b1;
        tick();
        hcomp    = 1'b0;
        exp_wsel = ~exp_wsel;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, busy, 1'b0);
        tick(2);
    endtask

    function automatic int addr_bad(input logic [9:0] ln, input logic [9:0] xs, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (acc_base + i >= acc_q.size()) bad++;
            else if (acc_q[acc_base + i] !== {ln, 10'(xs + 10'(i))}) bad++;
        end
        return bad;
    endfunction

    logic [19:0] t2_exp [8] = '{20'h01BFC, 20'h01BFD, 20'h01BFE, 20'h01BFF,
                                20'h01800, 20'h01801, 20'h01802, 20'h01803};

    initial begin
        int sbad;
        int n;
        int w0;
        int rv0;

        rstn = 1'b0;
        tick(3);
        chk("rst_req", vram_req, 0);
        chk("rst_addr", vram_addr, 0);
        chk("rst_we", lram_we, 0);
        chk("rst_wadr", lram_wadr, 0);
        chk("rst_wdat", lram_wdat, 0);
        chk("rst_wsel", lram_wsel, 1);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        rstn = 1'b1;
        tick(2);

        // Full line from yscroll=5
        vrtc = 1'b1;
        yscroll = 10'd5;
        vpstart = 1'b1;
        tick();
        vpstart = 1'b0;
        tick();
        max_out = 0;
        start_fill(10'd5, 10'd0);
        chk("t1_busy", busy, 1);
        chk("t1_first_addr", vram_addr, 20'h01400);
        chk("t1_wsel", lram_wsel, 0);
        wait_idle("t1_done", 3000);
        chk("t1_wr_cnt", wr_cnt, 512);
        chk("t1_wr_bad", wr_bad, 0);
        chk("t1_acc_cnt", acc_q.size() - acc_base, 512);
        chk("t1_acc_bad", addr_bad(10'd5, 10'd0, 512), 0);
        chk("t1_last_addr", acc_q[acc_base + 511], 20'h015FF);
        chk("t1_max_out", max_out, 2);

        // x wrap at 1024 words
        start_fill(10'd6, 10'd1020);
        wait_idle("t2_done", 3000);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_addr%0d", i), acc_q[acc_base + i], t2_exp[i]);
        chk("t2_acc_bad", addr_bad(10'd6, 10'd1020, 512), 0);
        chk("t2_wr_cnt", wr_cnt, 512);
        chk("t2_wr_bad", wr_bad, 0);

        // Ack withheld: request and address hold
        ack_en = 1'b0;
        max_out = 0;
        start_fill(10'd7, 10'd0);
        sbad = 0;
        for (int i = 0; i < 10; i++) begin
            if (vram_req !== 1'b1 || vram_addr !== 20'h01C00) sbad++;
            tick();
        end
        chk("t3_stable", sbad, 0);
        chk("t3_no_wr", wr_cnt, 0);
        ack_en = 1'b1;
        wait_idle("t3_done", 3000);
        chk("t3_wr_cnt", wr_cnt, 512);
        chk("t3_wr_bad", wr_bad, 0);
        chk("t3_max_out", max_out, 2);

        // Underrun with two reads outstanding
        start_fill(10'd8, 10'd0);
        n = 0;
        while ((acc_q.size() - acc_base) < 100 && n < 2000) begin
            tick();
            n++;
        end
        chk("t4_reach100", (acc_q.size() - acc_base) >= 100, 1);
        rv_en = 1'b0;
        tick(4);
        chk("t4_out2", rq.size(), 2);
        chk("t4_no_unr_yet", underrun, 0);
        hcomp = 1'b1;
        tick();
        hcomp = 1'b0;
        exp_wsel = ~exp_wsel;
        mon_line = 10'd9;
        mon_xs = 10'd0;
        mon_next = 0;
        wr_cnt = 0;
        wr_bad = 0;
        mon_wsel = exp_wsel;
        acc_base = acc_q.size();
        chk("t4_underrun", underrun, 1);
        chk("t4_busy", busy, 1);
        chk("t4_req_drain", vram_req, 0);
        rv0 = rv_cnt;
        rv_en = 1'b1;
        tick(2);
        chk("t4_beats_disc", rv_cnt - rv0, 2);
        chk("t4_restart_addr", vram_addr, 20'h02400);
        chk("t4_restart_req", vram_req, 1);
        wait_idle("t4_done", 3000);
        chk("t4_wr_cnt", wr_cnt, 512);
        chk("t4_wr_bad", wr_bad, 0);
        chk("t4_acc_bad", addr_bad(10'd9, 10'd0, 512), 0);
`ifdef LFILL_UNDERRUN_CNT_EN
        chk("t4_cnt", underrun_cnt, 1);
`endif
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        chk("t4_clr", underrun, 0);

        // Ack and rvalid on the same cycle
        lat = 1;
        both_cnt = 0;
        start_fill(10'd10, 10'd0);
        chk("t5_first_addr", vram_addr, 20'h02800);
        wait_idle("t5_done", 3000);
        chk("t5_both20", both_cnt >= 20, 1);
        chk("t5_wr_cnt", wr_cnt, 512);
        chk("t5_wr_bad", wr_bad, 0);
        chk("t5_acc_cnt", acc_q.size() - acc_base, 512);

        // Outside the active window the line counter holds
        vrtc = 1'b0;
        start_fill(10'd11, 10'd0);
        chk("t6_line_a", vram_addr, 20'h02C00);
        wait_idle("t6_done_a", 3000);
        start_fill(10'd11, 10'd0);
        chk("t6_line_held", vram_addr, 20'h02C00);
        wait_idle("t6_done_b", 3000);
        chk("t6_wr_bad", wr_bad, 0);

        // Reset mid-fill; late beats must not write
        vrtc = 1'b1;
        lat = 2;
        start_fill(10'd11, 10'd0);
        tick(50);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_wsel = 1'b1;
        chk("t7_busy", busy, 0);
        chk("t7_req", vram_req, 0);
        chk("t7_wsel", lram_wsel, 1);
        w0 = wr_cnt;
        n = 0;
        while (rq.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        tick(2);
        chk("t7_late_wr", wr_cnt - w0, 0);
        start_fill(10'd0, 10'd3);
        chk("t7_line_rst", vram_addr, 20'h00003);
        wait_idle("t7_done", 3000);
        chk("t7_wr_bad", wr_bad, 0);

        // Underrun set wins over simultaneous clear
        start_fill(10'd1, 10'd0);
        tick(20);
        hcomp = 1'b1;
        clr_underrun = 1'b1;
        tick();
        hcomp = 1'b0;
        clr_underrun = 1'b0;
        exp_wsel = ~exp_wsel;
        mon_line = 10'd2;
        mon_next = 0;
        wr_cnt = 0;
        wr_bad = 0;
        mon_wsel = exp_wsel;
        chk("t8_set_wins", underrun, 1);
        wait_idle("t8_done", 3000);
        chk("t8_wr_cnt", wr_cnt, 512);
        chk("t8_wr_bad", wr_bad, 0);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        chk("t8_clr", underrun, 0);

`ifdef LFILL_UNDERRUN_CNT_EN
        chk("t9_cnt0", underrun_cnt, 0);
        start_fill(10'd3, 10'd0);
        for (int i = 0; i < 300; i++) begin
            hcomp = 1'b1;
            tick();
            hcomp = 1'b0;
            tick();
        end
        chk("t9_cnt_sat", underrun_cnt, 255);
        chk("t9_flag", underrun, 1);
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        chk("t9_cnt_clr", underrun_cnt, 0);
        chk("t9_flag_clr", underrun, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
